dmux_stream: RTL
================

// Module: dmux_stream
// PURPOSE
//  Registered, parametrised 1-to-CH stream demultiplexer with valid/ready flow control.
//  Each beat is steered to one output channel by in_sel, or to all enabled channels by in_bcast.
//  Each channel owns a one-entry output register, so a stalled channel does not corrupt others.
//  Disabled channels drop their beats and count the drops.
//  Feeds per-unit queues downstream of a shared input bus.
// PARAMETERS
//  WIDTH  16  data width per beat
//  SELW   3   select width; CH = 2**SELW (default 8 channels)
//  CNTW   16  drop counter width
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           asynchronous, active-high reset
//  in_data     in   WIDTH       input beat
//  in_sel      in   SELW        target channel (ignored when in_bcast=1)
//  in_bcast    in   1           broadcast beat to every enabled channel
//  in_valid    in   1           input beat present
//  in_ready    out  1           input beat accepted when in_valid&in_ready
//  chan_en     in   CH          per-channel enable; 0 = drop beats to that channel
//  out_data    out  CH*WIDTH    channel k data at [k*WIDTH +: WIDTH]
//  out_valid   out  CH          channel k register full
//  out_ready   in   CH          channel k consumer ready
//  drop_cnt    out  CNTW        saturating count of dropped beats
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_data=0, drop_cnt=0. Held until reset falls.
//  Channel register k is free when !out_valid[k] | out_ready[k].
//  Target set T:
//   - in_bcast=0: T = {in_sel}.
//   - in_bcast=1: T = {k | chan_en[k]}.
//  in_ready (combinational):
//   - Equals AND of free[k] over T. Does not depend on in_valid.
//   - T empty: in_ready=1.
//  Accept = in_valid & in_ready.
//  On the clock edge after accept:
//   - Every k in T with chan_en[k]=1 loads in_data; out_valid[k] becomes 1.
//  Drops:
//   - Unicast to a channel with chan_en[in_sel]=0: beat consumed, no channel loaded, drop_cnt+1.
//   - Broadcast with T empty: beat consumed, drop_cnt+1 (one per beat).
//  drop_cnt saturates at all-ones; it never wraps.
//  Latency: accepted beat is visible on out_valid/out_data exactly 1 cycle later.
//  Output handshake, per channel, each edge:
//   - out_valid[k]&out_ready[k] & no load: out_valid[k] -> 0.
//   - Drain and new load on the same edge: out_valid[k] stays 1 with the new data, so a channel
//     sustains 1 beat/cycle.
//  Stall: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is held stable.
//  Independence: a stalled channel blocks only beats whose T includes it.
//  Broadcast is all-or-nothing: no partial load when any target is busy.
//  chan_en affects new accepts only; it does not flush a full register.
//  Reset mid-transfer: all held beats are discarded; no out_valid pulses after reset.
//  No internal state machine beyond the CH valid bits, the data registers and drop_cnt.
// TESTING
//  1 Reset then unicast sel=5, data=16'hA5A5, out_ready=all 1 -> next cycle out_valid=8'h20,
//    ch5 data=A5A5; following cycle out_valid=0.
//  2 Stream 4 beats to ch2 with out_ready[2]=1 -> in_ready stays 1; one beat/cycle on ch2 in order.
//  3 ch3 out_ready=0, holding 16'h1111 -> a beat to ch3 stalls (in_ready=0);
//    a beat to ch4 is accepted; ch3 data holds 1111.
//  4 bcast data=16'h00FF, chan_en=8'hF0 -> ch4..7 load 00FF; ch0..3 stay empty; drop_cnt=0.
//    Repeat with ch6 stalled -> in_ready=0 and no channel loads.
//  5 chan_en=0, 3 unicast beats -> in_ready=1, all consumed, drop_cnt=3.
//    With CNTW=2, 5 drops -> drop_cnt=3 (saturated).
//  6 Assert reset while ch1, ch7 are full and stalled -> out_valid=0 immediately;
//    after release, no stale beats appear.

Source files
------------

// File: rtl/dmux_stream.sv
// 1-to-CH stream demux: one-entry register per channel, 1-cycle latency.
// in_ready drops only when a busy channel in the target set blocks the beat.
module dmux_stream #(
    parameter int  WIDTH = 16,
    parameter int  SELW  = 3,
    parameter int  CNTW  = 16,
    localparam int CH    = 2 ** SELW
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH-1:0]         chan_en,
    output logic [CH*WIDTH-1:0]   out_data,
    output logic [CH-1:0]         out_valid,
    input  logic [CH-1:0]         out_ready,
    output logic [CNTW-1:0]       drop_cnt
);

    logic [CH-1:0]            out_valid_q, out_valid_d;
    logic [CH-1:0][WIDTH-1:0] data_q, data_d;
    logic [CNTW-1:0]          drop_cnt_q, drop_cnt_d;

    logic [CH-1:0] free;
    logic [CH-1:0] tgt;
    logic [CH-1:0] load;
    logic          accept;
    logic          drop;

    always_comb begin
        free     = ~out_valid_q | out_ready;
        tgt      = in_bcast ? chan_en : (CH'(1) << in_sel);
        // Channels outside the target set never block; an empty set always accepts.
        in_ready = &(free | ~tgt);
        accept   = in_valid & in_ready;
        load     = accept ? (tgt & chan_en) : '0;
        drop     = accept & ~(|load);

        out_valid_d = load | (out_valid_q & ~out_ready);
        for (int k = 0; k < CH; k++) begin
            data_d[k] = load[k] ? in_data : data_q[k];
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= '0;
            data_q      <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
